cpu_exec_sequencer: RTL and testbench
=====================================

# cpu_exec_sequencer

- Multi-cycle control FSM that drives the CPU datapath through fetch, decode and execute.
- Fetches each 32-bit instruction as four bytes over the 8-bit memory bus and presents it to the instruction decoder.
- Samples the decoder's condition result and execution-step request, then emits one-hot phase strobes (reg_r, mem_r, mem_w, reg_w, end_inst) in a fixed order.
- Owns the program counter, jumps and HLT.

## Interface
- `WD_LIMIT`, 16: memory-wait watchdog limit in cycles; used only with `CPU_SEQ_WATCHDOG_EN`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE/HALT and begin fetching at `pc`.
- `mem_addr` out 8: fetch byte address; valid while `fetch_active`.
- `mem_rd` out 1: fetch read request.
- `mem_rdata` in 8: read data; valid when `mem_ready`.
- `mem_ready` in 1: memory completion for fetch and for the mem_r/mem_w phases.
- `fetch_active` out 1: sequencer owns the memory bus (FETCH state).
- `inst` out 32: assembled instruction register, fed to the decoder.
- `cond_pass` in 1: decoder condition result.
- `step_mask` in 4: requested phases {reg_w, mem_w, mem_r, reg_r}.
- `halt_req` in 1: decoder flags HLT.
- `jump_valid` in 1: decoder flags a jump.
- `jump_target` in 8: jump target address.
- `reg_r` out 1, `mem_r` out 1, `mem_w` out 1, `reg_w` out 1: phase strobes.
- `end_inst` out 1: instruction retire strobe.
- `pc` out 8: program counter.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `fault` out 1: watchdog abort flag; sticky until `rst` or `start`.

## Operation
- States: IDLE, FETCH, DECODE, REG_RD, MEM_RD, MEM_WR, REG_WR, END, HALT.
- Reset: state IDLE, `pc`=0, `inst`=0, byte counter 0. All outputs are 0 except `mem_addr`=0.
- `rst` overrides every other input, including mid-instruction. No strobe fires in the reset cycle's successor.

IDLE / HALT
- `start`=1 → FETCH with byte counter 0.
- `start` also clears `fault`.
- `start` is ignored in all other states.

FETCH
- `mem_rd`=1, `fetch_active`=1, `mem_addr`=(pc+k) mod 256, where k = byte counter 0..3.
- On `mem_ready`, byte k is captured big-endian: k=0 → inst[31:24], k=3 → inst[7:0]; k then increments.
- After the k=3 capture → DECODE.
- Without `mem_ready`, all outputs are held.

DECODE
- One cycle. Samples `cond_pass`, `step_mask`, `halt_req`, `jump_valid`, `jump_target` into internal registers.
- Decoder inputs are ignored outside this cycle.

Execute
- If latched `cond_pass`=0: go directly to END; no phase strobes; jump and halt are suppressed.
- Otherwise visit REG_RD → MEM_RD → MEM_WR → REG_WR, skipping states whose mask bit is 0, then END.
- Mask 0 with cond_pass=1 → END directly.

Phase states
- Each phase state asserts its strobe for exactly one cycle (REG_RD, REG_WR).
- MEM_RD and MEM_WR hold their strobe until `mem_ready`, then advance.

END
- `end_inst`=1 for one cycle.
- If cond_pass & halt_req → HALT, `pc` unchanged.
- Otherwise `pc` ← jump_target if cond_pass & jump_valid, else (pc+4) mod 256. Then → FETCH.
- halt_req and jump_valid both set: halt wins.

## Timing
- Strobes and `mem_rd` are registered state decodes; no combinational path from inputs to outputs.
- With `mem_ready` tied 1:
  - NOP: 4 fetch + 1 decode + 1 end = 6 cycles.
  - All four phases: 10 cycles.
  - Each mem wait cycle adds 1.
- `end_inst` of instruction N is followed on the next cycle by `mem_rd`=1 at the new `pc`.
- `pc` updates on the END→FETCH edge.
- `inst` is stable from DECODE until the next FETCH byte 0 capture.
- At most one of reg_r/mem_r/mem_w/reg_w/end_inst is high in any cycle.

## Configuration
- `CPU_SEQ_WATCHDOG_EN` defined:
  - A 5-bit counter counts consecutive cycles in FETCH, MEM_RD or MEM_WR without `mem_ready`.
  - It resets on `mem_ready` and on every state change.
  - Reaching `WD_LIMIT` → HALT with `fault`=1, `end_inst` not asserted, `pc` unchanged.
- Undefined: `fault` tied 0; the sequencer waits indefinitely for `mem_ready`.

## Test plan
- Reset, `start`, `mem_ready`=1, memory bytes 0x00,0x00,0x12,0x34 at 0..3, cond_pass=1, mask=0 → inst=0x00001234, `end_inst` in cycle 6, `pc`=4.
- cond_pass=1, mask=4'b1111, mem_ready=1 → strobes in order reg_r, mem_r, mem_w, reg_w, end_inst on consecutive cycles 6-10.
- cond_pass=0, mask=4'b1111, jump_valid=1, target=0x40 → no phase strobes, `pc`=4.
- `pc`=0xFC, fetch → addresses 0xFC,0xFD,0xFE,0xFF; next `pc`=0x00. cond_pass=1, jump_valid=1, target=0x80 → `pc`=0x80.
- halt_req=1, cond_pass=1 → `halted`=1, `pc` unchanged, `start` resumes fetch at same `pc`. `rst` asserted in MEM_RD → IDLE, `pc`=0, strobes 0.
- `CPU_SEQ_WATCHDOG_EN`, `mem_ready` held 0 in MEM_RD for 16 cycles → `fault`=1, `halted`=1, no `end_inst`.

Source files
------------

// File: rtl/cpu_exec_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM: four-byte fetch, one-hot phase strobes, PC/jump/HLT.
// Optional memory-wait watchdog enabled by defining CPU_SEQ_WATCHDOG_EN.
module cpu_exec_sequencer #(
  parameter int WD_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        fetch_active,
  output logic [31:0] inst,
  input  logic        cond_pass,
  input  logic [3:0]  step_mask,
  input  logic        halt_req,
  input  logic        jump_valid,
  input  logic [7:0]  jump_target,
  output logic        reg_r,
  output logic        mem_r,
  output logic        mem_w,
  output logic        reg_w,
  output logic        end_inst,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REG_RD, S_MEM_RD, S_MEM_WR, S_REG_WR, S_END, S_HALT
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic        cond_q, halt_q, jump_q, fault_q;
  logic [3:0]  mask_q;
  logic [7:0]  target_q;
  logic        wd_trip;

  // First remaining phase in fixed order reg_r, mem_r, mem_w, reg_w; none left means END.
  function automatic state_t phase_next(input logic [3:0] m);
    if (m[0])      return S_REG_RD;
    else if (m[1]) return S_MEM_RD;
    else if (m[2]) return S_MEM_WR;
    else if (m[3]) return S_REG_WR;
    else           return S_END;
  endfunction

`ifdef CPU_SEQ_WATCHDOG_EN
  logic [4:0] wd_cnt;
  logic       waiting;

  assign waiting = !mem_ready &&
                   (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
  assign wd_trip = waiting && (wd_cnt == 5'(WD_LIMIT - 1));

  // Any cycle that is not a continued wait (ready, other state, or trip) restarts the count.
  always_ff @(posedge clk) begin
    if (rst)                      wd_cnt <= '0;
    else if (waiting && !wd_trip) wd_cnt <= wd_cnt + 5'd1;
    else                          wd_cnt <= '0;
  end
`else
  // Watchdog compiled out: never trips, so memory waits are unbounded.
  assign wd_trip = (WD_LIMIT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      inst     <= '0;
      byte_cnt <= '0;
      cond_q   <= 1'b0;
      halt_q   <= 1'b0;
      jump_q   <= 1'b0;
      mask_q   <= '0;
      target_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          state    <= S_FETCH;
          byte_cnt <= '0;
          fault_q  <= 1'b0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            case (byte_cnt)
              2'd0: inst[31:24] <= mem_rdata;
              2'd1: inst[23:16] <= mem_rdata;
              2'd2: inst[15:8]  <= mem_rdata;
              default: inst[7:0] <= mem_rdata;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_DECODE;
          end else if (wd_trip) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_DECODE: begin
          cond_q   <= cond_pass;
          mask_q   <= step_mask;
          halt_q   <= halt_req;
          jump_q   <= jump_valid;
          target_q <= jump_target;
          state    <= cond_pass ? phase_next(step_mask) : S_END;
        end
        S_REG_RD: state <= phase_next(mask_q & 4'b1110);
        S_MEM_RD: begin
          if (mem_ready) state <= phase_next(mask_q & 4'b1100);
          else if (wd_trip) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) state <= phase_next(mask_q & 4'b1000);
          else if (wd_trip) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_REG_WR: state <= S_END;
        S_END: begin
          if (cond_q && halt_q) state <= S_HALT;
          else begin
            pc       <= (cond_q && jump_q) ? target_q : pc + 8'd4;
            byte_cnt <= '0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; no input reaches an output combinationally.
  assign mem_rd       = (state == S_FETCH);
  assign fetch_active = (state == S_FETCH);
  assign mem_addr     = pc + {6'd0, byte_cnt};
  assign reg_r        = (state == S_REG_RD);
  assign mem_r        = (state == S_MEM_RD);
  assign mem_w        = (state == S_MEM_WR);
  assign reg_w        = (state == S_REG_WR);
  assign end_inst     = (state == S_END);
  assign busy         = (state != S_IDLE) && (state != S_HALT);
  assign halted       = (state == S_HALT);
  assign fault        = fault_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Bench for cpu_exec_sequencer: expected phase sequence per instruction built from the
// instruction's latched decode fields, with randomized memory latency and decoder noise.
module tb_cpu_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, mem_rd, mem_ready, fetch_active;
  logic [7:0]  mem_addr, mem_rdata, jump_target, pc;
  logic [31:0] inst;
  logic        cond_pass, halt_req, jump_valid;
  logic [3:0]  step_mask;
  logic        reg_r, mem_r, mem_w, reg_w, end_inst, busy, halted, fault;

  cpu_exec_sequencer #(.WD_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .fetch_active(fetch_active),
    .inst(inst), .cond_pass(cond_pass), .step_mask(step_mask), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_target(jump_target), .reg_r(reg_r), .mem_r(mem_r),
    .mem_w(mem_w), .reg_w(reg_w), .end_inst(end_inst), .pc(pc), .busy(busy),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Step kinds of the expected per-instruction sequence.
  localparam int K_F = 0, K_D = 1, K_RR = 2, K_MR = 3, K_MW = 4, K_RW = 5, K_E = 6,
                 K_IDLE = 7, K_HALT = 8;

  logic [7:0] mem [256];
  logic [7:0] m_pc;
  logic       m_fault, m_halt;
  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctl_now();
    return {mem_rd, fetch_active, reg_r, mem_r, mem_w, reg_w, end_inst, busy, halted, fault};
  endfunction

  // Bits: mem_rd, fetch_active, reg_r, mem_r, mem_w, reg_w, end_inst, busy, halted, fault
  function automatic logic [9:0] exp_ctl(input int kind);
    logic [9:0] v;
    case (kind)
      K_F:     v = 10'b11_0000_0_1_0_0;
      K_D:     v = 10'b00_0000_0_1_0_0;
      K_RR:    v = 10'b00_1000_0_1_0_0;
      K_MR:    v = 10'b00_0100_0_1_0_0;
      K_MW:    v = 10'b00_0010_0_1_0_0;
      K_RW:    v = 10'b00_0001_0_1_0_0;
      K_E:     v = 10'b00_0000_1_1_0_0;
      K_HALT:  v = 10'b00_0000_0_0_1_0;
      default: v = 10'b0;
    endcase
    v[0] = m_fault;
    return v;
  endfunction

  task automatic do_start(input int kind);
    #1;
    chk("pre_start_ctl", {22'd0, ctl_now()}, {22'd0, exp_ctl(kind)});
    chk("pre_start_pc", {24'd0, pc}, {24'd0, m_pc});
    start = 1'b1;
    mem_ready = 1'($urandom);
    @(posedge clk);
    m_fault = 1'b0;
    m_halt  = 1'b0;
  endtask

  // mode: 0 random latency, 1 ready always, 2 reset during MEM_RD, 3 hold MEM_RD not-ready.
  task automatic exec_inst(input bit cond, input logic [3:0] mask, input bit hlt,
                           input bit jv, input logic [7:0] jt, input int mode);
    int q[$];
    int k = 0, stall = 0, cyc = 0, cur;
    bit rdy, wd_hit = 0;
    logic [7:0] a0, a1, a2, a3, a;
    logic [31:0] exp_inst;
    a0 = m_pc; a1 = m_pc + 8'd1; a2 = m_pc + 8'd2; a3 = m_pc + 8'd3;
    exp_inst = {mem[a0], mem[a1], mem[a2], mem[a3]};
    q = '{K_F, K_F, K_F, K_F, K_D};
    if (cond) begin
      if (mask[0]) q.push_back(K_RR);
      if (mask[1]) q.push_back(K_MR);
      if (mask[2]) q.push_back(K_MW);
      if (mask[3]) q.push_back(K_RW);
    end
    q.push_back(K_E);
    while (q.size() > 0 && cyc < 300) begin
      #1;
      cur = q[0];
      a = m_pc + 8'(k);
      chk("ctl", {22'd0, ctl_now()}, {22'd0, exp_ctl(cur)});
      chk("pc", {24'd0, pc}, {24'd0, m_pc});
      if (cur == K_F) chk("mem_addr", {24'd0, mem_addr}, {24'd0, a});
      else            chk("inst", inst, exp_inst);
      rdy = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (stall >= 8 && mode != 3) rdy = 1'b1;
      if (cur == K_MR && (mode == 2 || mode == 3)) rdy = 1'b0;
      if (cur == K_MR && mode == 2) rst = 1'b1;
      start       = 1'($urandom);
      mem_ready   = rdy;
      mem_rdata   = (cur == K_F && rdy) ? mem[a] : 8'($urandom);
      cond_pass   = (cur == K_D) ? cond : 1'($urandom);
      step_mask   = (cur == K_D) ? mask : 4'($urandom);
      halt_req    = (cur == K_D) ? hlt  : 1'($urandom);
      jump_valid  = (cur == K_D) ? jv   : 1'($urandom);
      jump_target = (cur == K_D) ? jt   : 8'($urandom);
      @(posedge clk);
      cyc++;
      if (rst) begin
        #1;
        rst = 1'b0; start = 1'b0;
        m_pc = 8'd0; m_fault = 1'b0; m_halt = 1'b0;
        chk("rst_ctl", {22'd0, ctl_now()}, {22'd0, exp_ctl(K_IDLE)});
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        @(posedge clk);
        return;
      end
      if (cur == K_F || cur == K_MR || cur == K_MW) begin
        if (rdy) begin void'(q.pop_front()); if (cur == K_F) k++; stall = 0; end
        else stall++;
      end else void'(q.pop_front());
      if (mode == 3 && stall == 16) begin wd_hit = 1; break; end
    end
    chk("timeout_left", q.size(), wd_hit ? q.size() : 0);
    if (wd_hit) begin
      m_fault = 1'b1; m_halt = 1'b1;
    end else if (cond && hlt) begin
      m_halt = 1'b1;
    end else begin
      m_pc = (cond && jv) ? jt : m_pc + 8'd4;
    end
    if (m_halt) begin
      #1;
      start = 1'b0;
      chk("halt_ctl", {22'd0, ctl_now()}, {22'd0, exp_ctl(K_HALT)});
      chk("halt_pc", {24'd0, pc}, {24'd0, m_pc});
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = 8'd0;
    cond_pass = 1'b0; step_mask = 4'd0; halt_req = 1'b0; jump_valid = 1'b0; jump_target = 8'd0;
    m_pc = 8'd0; m_fault = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h12; mem[3] = 8'h34;
    @(posedge clk); @(posedge clk);
    #1;
    chk("reset_ctl", {22'd0, ctl_now()}, 32'd0);
    chk("reset_pc", {24'd0, pc}, 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_addr", {24'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk);

    do_start(K_IDLE);
    exec_inst(1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1);   // NOP: inst 0x00001234, pc -> 4
    chk("nop_pc", {24'd0, m_pc}, 32'd4);
    exec_inst(1'b1, 4'b1111, 1'b0, 1'b0, 8'h00, 1);   // all phases back to back
    exec_inst(1'b0, 4'b1111, 1'b0, 1'b1, 8'h40, 1);   // condition fails: no strobes, no jump
    exec_inst(1'b1, 4'b0101, 1'b0, 1'b1, 8'hFC, 0);   // jump to 0xFC
    exec_inst(1'b1, 4'b0110, 1'b0, 1'b0, 8'h00, 0);   // fetch wraps 0xFC..0xFF, pc -> 0x00
    exec_inst(1'b1, 4'b1010, 1'b0, 1'b1, 8'h80, 0);   // jump to 0x80
    exec_inst(1'b1, 4'b0011, 1'b1, 1'b1, 8'h10, 0);   // HLT wins over jump
    do_start(K_HALT);
    exec_inst(1'b1, 4'b1111, 1'b0, 1'b0, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      exec_inst(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom), 8'($urandom), 0);
      if (m_halt) do_start(K_HALT);
    end

`ifdef CPU_SEQ_WATCHDOG_EN
    exec_inst(1'b1, 4'b0010, 1'b0, 1'b0, 8'h00, 3);   // MEM_RD never ready -> fault halt
    do_start(K_HALT);
    exec_inst(1'b1, 4'b0001, 1'b0, 1'b0, 8'h00, 0);
`endif

    exec_inst(1'b1, 4'b0011, 1'b0, 1'b0, 8'h00, 2);   // reset during MEM_RD
    do_start(K_IDLE);
    exec_inst(1'b1, 4'b1001, 1'b0, 1'b0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
